// File: rtl/pipe_addsub_pkg.sv
// -----------------------------------------------------------------------------
// pipe_addsub_pkg
// Shared definitions for the pipelined adder/subtractor:
//   - default WIDTH / STAGES values and the widest supported operand
//   - slice_width(): bits handled by each pipeline stage
//   - stage_t: the per-stage register record. Data fields are sized for the
//     widest legal operand so one typedef serves every parameterisation; an
//     instance only uses the low WIDTH bits of res/rem_x/rem_y.
// -----------------------------------------------------------------------------
package pipe_addsub_pkg;

  localparam int PIPE_WIDTH_DEF  = 32;
  localparam int PIPE_STAGES_DEF = 4;
  localparam int PIPE_MAX_WIDTH  = 64;

  // Number of result bits produced by each stage.
  function automatic int slice_width(input int width, input int stages);
    return width / stages;
  endfunction

  typedef struct packed {
    logic                      valid;   // stage holds an operand set
    logic [PIPE_MAX_WIDTH-1:0] res;     // finished low result bits
    logic                      carry;   // carry out of the last finished slice
    logic [PIPE_MAX_WIDTH-1:0] rem_x;   // unprocessed x bits, right-aligned
    logic [PIPE_MAX_WIDTH-1:0] rem_y;   // unprocessed effective-y bits, right-aligned
    logic                      x_sign;  // sign of x
    logic                      y_sign;  // sign of effective y (after inversion)
  } stage_t;

endpackage

// File: rtl/pipe_addsub_slice.sv
// -----------------------------------------------------------------------------
// add_slice
// Purely combinational SW-bit adder slice with carry in/out. This is the only
// place in the design where arithmetic is written.
// Ports:
//   a, b  [SW-1:0]  in   slice operands
//   ci              in   carry into the slice
//   sum   [SW-1:0]  out  slice sum
//   co              out  carry out of the slice
// -----------------------------------------------------------------------------
module add_slice #(
  parameter int SW = 8
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          ci,
  output logic [SW-1:0] sum,
  output logic          co
);

  logic [SW:0] total_s;

  assign total_s = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, ci};
  assign sum     = total_s[SW-1:0];
  assign co      = total_s[SW];

endmodule

// File: rtl/pipe_addsub.sv
// -----------------------------------------------------------------------------
// pipe_addsub
// Pipelined add/subtract with valid/ready handshakes on both sides. The
// WIDTH-bit addition is cut into STAGES slices; stage k adds slice k plus the
// registered carry of stage k-1, so no carry chain crosses a register.
// Subtraction is x + ~y + !cin (cin acts as borrow-in, cout=1 means no borrow).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input handshake; x, y, cin, sub sampled on transfer
//   out_valid/out_ready output handshake; s, cout, ovf valid with out_valid
// -----------------------------------------------------------------------------
module pipe_addsub
  import pipe_addsub_pkg::*;
#(
  parameter int WIDTH  = PIPE_WIDTH_DEF,
  parameter int STAGES = PIPE_STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int SW = slice_width(WIDTH, STAGES);

  if (WIDTH < 2 || WIDTH > PIPE_MAX_WIDTH || STAGES < 1 || STAGES > WIDTH ||
      (WIDTH % STAGES) != 0) begin : g_bad_params
    $error("pipe_addsub: illegal WIDTH/STAGES combination");
  end

  stage_t             pipe_q [STAGES];
  logic [STAGES-1:0]  valid_s;
  logic [STAGES-1:0]  adv_s;       // stage k hands its record on this cycle
  logic               accept_s;
  logic [WIDTH-1:0]   y_eff_s;
  logic               unused_par_s;

  assign y_eff_s = sub ? ~y : y;

  // Ready chain, walked from the output back: a stage may release when the
  // stage after it is empty or releasing too.
  always_comb begin
    logic down_free;
    down_free = out_ready;
    adv_s     = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      adv_s[k]  = valid_s[k] && down_free;
      down_free = !valid_s[k] || adv_s[k];
    end
    in_ready = down_free && !rst;
    accept_s = in_valid && in_ready;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t          stage_q;
    stage_t          stage_d;
    stage_t          stage_in;
    logic [SW-1:0]   a_s;
    logic [SW-1:0]   b_s;
    logic [SW-1:0]   sum_s;
    logic            ci_s;
    logic            co_s;
    logic            load_s;

    if (k == 0) begin : g_first
      assign a_s    = x[SW-1:0];
      assign b_s    = y_eff_s[SW-1:0];
      assign ci_s   = cin ^ sub;
      assign load_s = accept_s;

      // First stage: build a fresh record from the accepted operand set.
      always_comb begin
        stage_in                  = '0;
        stage_in.valid            = 1'b1;
        stage_in.res[SW-1:0]      = sum_s;
        stage_in.carry            = co_s;
        stage_in.rem_x[WIDTH-1:0] = x;
        stage_in.rem_y[WIDTH-1:0] = y_eff_s;
        stage_in.rem_x            = stage_in.rem_x >> SW;
        stage_in.rem_y            = stage_in.rem_y >> SW;
        stage_in.x_sign           = x[WIDTH-1];
        stage_in.y_sign           = y_eff_s[WIDTH-1];
      end
    end else begin : g_next
      assign a_s    = pipe_q[k-1].rem_x[SW-1:0];
      assign b_s    = pipe_q[k-1].rem_y[SW-1:0];
      assign ci_s   = pipe_q[k-1].carry;
      assign load_s = adv_s[k-1];

      // Later stage: extend the upstream record by one finished slice.
      always_comb begin
        stage_in                   = pipe_q[k-1];
        stage_in.valid             = 1'b1;
        stage_in.res[k*SW +: SW]   = sum_s;
        stage_in.carry             = co_s;
        stage_in.rem_x             = pipe_q[k-1].rem_x >> SW;
        stage_in.rem_y             = pipe_q[k-1].rem_y >> SW;
      end
    end

    add_slice #(.SW(SW)) u_slice (
      .a   (a_s),
      .b   (b_s),
      .ci  (ci_s),
      .sum (sum_s),
      .co  (co_s)
    );

    // Next record: load from upstream, empty on release, otherwise hold.
    always_comb begin
      stage_d = stage_q;
      if (load_s) begin
        stage_d = stage_in;
      end else if (adv_s[k]) begin
        stage_d.valid = 1'b0;
      end else begin
        stage_d = stage_q;
      end
    end

    // Stage register with synchronous clear.
    always_ff @(posedge clk) begin
      if (rst) begin
        stage_q <= '0;
      end else begin
        stage_q <= stage_d;
      end
    end

    assign pipe_q[k]  = stage_q;
    assign valid_s[k] = stage_q.valid;
  end

  assign out_valid = pipe_q[STAGES-1].valid;
  assign s         = pipe_q[STAGES-1].res[WIDTH-1:0];
  assign cout      = pipe_q[STAGES-1].carry;
  // Overflow: both effective operands agree in sign but the result does not.
  assign ovf       = (pipe_q[STAGES-1].x_sign == pipe_q[STAGES-1].y_sign) &&
                     (s[WIDTH-1] != pipe_q[STAGES-1].x_sign);

  // Sink for record bits no stage reads (padding above WIDTH, spent operands).
  always_comb begin
    unused_par_s = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      unused_par_s = unused_par_s ^ (^pipe_q[k]);
    end
  end

endmodule
